// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipeline control slice: word/register types,
// writeback-source encoding and the stall/flush sequencer state enum.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    localparam logic [1:0] MEMTOREG_LOAD = 2'd2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } pctl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an IF/ID instruction that reads the register
// a load in ID/EX is about to write. Purely combinational.
module hazard_detect
    import cpu_types_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              regwrite_i,
    input  logic [1:0]        memtoreg_i,
    input  logic [REG_AW-1:0] dest_i,
    input  word_t             instr_i,
    output logic              load_use_o
);

    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              unused_instr_bits;

    assign rs = REG_AW'(instr_i[25:21]);
    assign rt = REG_AW'(instr_i[20:16]);

    // opcode/funct/immediate fields play no part in the register compare
    assign unused_instr_bits = ^{instr_i[31:26], instr_i[15:0]};

    assign load_use_o = regwrite_i
                     && (memtoreg_i == MEMTOREG_LOAD)
                     && (dest_i != '0)
                     && ((dest_i == rs) || (dest_i == rt));

endmodule

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, dmem wait,
// taken branch, halt). Optional perf counters enabled by PIPE_PERF_EN.
//
//   state  | meaning
//   RUN    | normal issue, hazards resolved by priority each cycle
//   DWAIT  | pipeline frozen waiting for the data port to hit
//   HALTED | halt retired; everything idle until RST
module pipeline_control
    import cpu_types_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int DWAIT_TIMEOUT = 255,
    parameter int CNT_W         = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dmem_req_mem,
    input  logic              regwrite_id_ex,
    input  logic [1:0]        memtoreg_id_ex,
    input  logic [REG_AW-1:0] dest_id_ex,
    input  word_t             instr_if_id,
    input  logic              pcsrc_taken_mem,
    input  logic              halt_mem_wb,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              imem_ren,
    output logic              halted,
    output logic              wait_err
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
`endif
);

    pctl_state_t state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d, wcnt_inc;
    logic        wait_err_q, wait_err_d;
    logic        load_use;
    logic        run_eval;
    logic        dmem_ok;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
        .regwrite_i (regwrite_id_ex),
        .memtoreg_i (memtoreg_id_ex),
        .dest_i     (dest_id_ex),
        .instr_i    (instr_if_id),
        .load_use_o (load_use)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= RUN;
            wcnt_q     <= '0;
            wait_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            wait_err_q <= wait_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        imem_ren     = 1'b0;
        run_eval     = 1'b0;
        dmem_ok      = 1'b1;

        case (state_q)
            RUN: begin
                run_eval = 1'b1;
                dmem_ok  = !(dmem_req_mem && !dhit);
            end
            DWAIT: begin
                // the hit cycle re-runs the RUN priorities with the data access done
                if (dhit) run_eval = 1'b1;
                else      mem_wb_flush = 1'b1;
            end
            default: ;
        endcase

        if (run_eval) begin
            imem_ren = 1'b1;
            state_d  = RUN;
            if (halt_mem_wb) begin
                state_d = HALTED;
            end else if (!dmem_ok) begin
                state_d      = DWAIT;
                mem_wb_flush = 1'b1;
                imem_ren     = 1'b0;
            end else if (pcsrc_taken_mem) begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                id_ex_en     = 1'b1;
                ex_mem_en    = 1'b1;
                mem_wb_en    = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use || !ihit) begin
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end
        end

        if (RST) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            mem_wb_flush = 1'b0;
            imem_ren     = 1'b0;
        end
    end

    always_comb begin
        wcnt_inc   = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
        wcnt_d     = '0;
        wait_err_d = wait_err_q;
        if (state_q == DWAIT) begin
            if ((DWAIT_TIMEOUT != 0) && (int'(wcnt_inc) == DWAIT_TIMEOUT))
                wait_err_d = 1'b1;
            if (state_d == DWAIT)
                wcnt_d = wcnt_inc;
        end
    end

    assign halted   = (state_q == HALTED);
    assign wait_err = wait_err_q;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // only a taken branch raises ex_mem_flush, so it marks one flush event
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (state_q != HALTED) && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (ex_mem_flush && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`else
    // counters and their ports are left out of this build
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Randomised + directed bench for pipeline_control against a cycle-level
// behavioural model of the stall/flush rules.
module tb_pipeline_control;
    import cpu_types_pkg::*;

    localparam int TO = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ihit = 1'b1, dhit = 1'b0, dmem_req_mem = 1'b0;
    logic       regwrite_id_ex = 1'b0;
    logic [1:0] memtoreg_id_ex = 2'd0;
    logic [4:0] dest_id_ex = 5'd0;
    word_t      instr_if_id = '0;
    logic       pcsrc_taken_mem = 1'b0, halt_mem_wb = 1'b0;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic imem_ren, halted, wait_err;
`ifdef PIPE_PERF_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    pipeline_control #(.REG_AW(5), .DWAIT_TIMEOUT(TO), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req_mem(dmem_req_mem),
        .regwrite_id_ex(regwrite_id_ex), .memtoreg_id_ex(memtoreg_id_ex),
        .dest_id_ex(dest_id_ex), .instr_if_id(instr_if_id),
        .pcsrc_taken_mem(pcsrc_taken_mem), .halt_mem_wb(halt_mem_wb),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .imem_ren(imem_ren), .halted(halted), .wait_err(wait_err)
`ifdef PIPE_PERF_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    always #5 CLK = ~CLK;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_f, id_ex_f, ex_mem_f, mem_wb_f, imem_ren}
    logic [9:0] ctl;
    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, imem_ren};

    localparam logic [9:0] C_IDLE   = 10'b0000000000;
    localparam logic [9:0] C_DSTALL = 10'b0000000010;
    localparam logic [9:0] C_HALT   = 10'b0000000001;
    localparam logic [9:0] C_BRANCH = 10'b1111111101;
    localparam logic [9:0] C_BUBBLE = 10'b0011101001;
    localparam logic [9:0] C_FLOW   = 10'b1111100001;

    int nvec = 0;
    int nerr = 0;

    // model: 0 = running, 1 = waiting on data port, 2 = halted
    int m_mode = 0;
    int m_wait = 0;
    bit m_err  = 1'b0;

    function automatic bit model_load_use();
        return regwrite_id_ex && (memtoreg_id_ex == 2'd2) && (dest_id_ex != 5'd0)
            && ((dest_id_ex == instr_if_id[25:21]) || (dest_id_ex == instr_if_id[20:16]));
    endfunction

    function automatic logic [9:0] model_ctl();
        bit mem_done;
        if (RST || m_mode == 2) return C_IDLE;
        if (m_mode == 1 && !dhit) return C_DSTALL;
        mem_done = (m_mode == 1) || !(dmem_req_mem && !dhit);
        if (halt_mem_wb)      return C_HALT;
        if (!mem_done)        return C_DSTALL;
        if (pcsrc_taken_mem)  return C_BRANCH;
        if (model_load_use() || !ihit) return C_BUBBLE;
        return C_FLOW;
    endfunction

    always @(negedge CLK) begin
        logic [9:0] exp_ctl;
        logic       exp_halt, exp_err;
        exp_ctl  = model_ctl();
        exp_halt = !RST && (m_mode == 2);
        exp_err  = !RST && m_err;
        nvec++;
        if (ctl !== exp_ctl || halted !== exp_halt || wait_err !== exp_err) begin
            nerr++;
            $display("FAIL cycle t=%0t ctl got %b want %b halted got %b want %b wait_err got %b want %b",
                     $time, ctl, exp_ctl, halted, exp_halt, wait_err, exp_err);
        end
        if (RST) begin
            m_mode = 0; m_wait = 0; m_err = 1'b0;
        end else if (m_mode == 0) begin
            if (halt_mem_wb) m_mode = 2;
            else if (dmem_req_mem && !dhit) m_mode = 1;
        end else if (m_mode == 1) begin
            m_wait++;
            if (TO != 0 && m_wait == TO) m_err = 1'b1;
            if (dhit) begin
                m_wait = 0;
                m_mode = halt_mem_wb ? 2 : 0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic lit(input string name, input logic [9:0] act, input logic [9:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %b want %b", name, act, want);
        end
    endtask

    task automatic chk(input string name, input logic [9:0] want);
        #3;
        lit(name, ctl, want);
        tick();
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; dmem_req_mem = 1'b0; regwrite_id_ex = 1'b0;
        memtoreg_id_ex = 2'd0; dest_id_ex = 5'd0; instr_if_id = '0;
        pcsrc_taken_mem = 1'b0; halt_mem_wb = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] d, input logic [4:0] rs, input logic [4:0] rt);
        regwrite_id_ex = 1'b1; memtoreg_id_ex = 2'd2; dest_id_ex = d;
        instr_if_id = {6'd0, rs, rt, 5'd3, 6'd0, 5'd0};
    endtask

    initial begin
        idle();
        RST = 1'b1;
        tick(); tick();
        #3;
        lit("reset_ctl", ctl, C_IDLE);
        lit("reset_flags", {8'd0, halted, wait_err}, 10'd0);
        tick();
        RST = 1'b0;
        tick();

        set_load(5'd5, 5'd5, 5'd7);  chk("loaduse_rs", C_BUBBLE);
        idle();                      chk("loaduse_release", C_FLOW);
        set_load(5'd7, 5'd1, 5'd7);  chk("loaduse_rt", C_BUBBLE);
        set_load(5'd0, 5'd0, 5'd0);  chk("dest0_nostall", C_FLOW);
        set_load(5'd9, 5'd5, 5'd7);  chk("mismatch_nostall", C_FLOW);
        idle(); ihit = 1'b0;         chk("imiss", C_BUBBLE);

        idle(); dmem_req_mem = 1'b1;
        chk("dwait_c1", C_DSTALL);
        chk("dwait_c2", C_DSTALL);
        chk("dwait_c3", C_DSTALL);
        dhit = 1'b1;                 chk("dwait_hit", C_FLOW);
        idle(); #3;
        lit("no_timeout", {9'd0, wait_err}, 10'd0);
        tick();

        set_load(5'd5, 5'd5, 5'd7); pcsrc_taken_mem = 1'b1; chk("branch_over_loaduse", C_BRANCH);
        idle(); pcsrc_taken_mem = 1'b1; ihit = 1'b0;        chk("branch_over_imiss", C_BRANCH);

        idle(); pcsrc_taken_mem = 1'b1; dmem_req_mem = 1'b1;
        chk("branch_wait_c1", C_DSTALL);
        chk("branch_wait_c2", C_DSTALL);
        dhit = 1'b1;                 chk("branch_wait_hit", C_BRANCH);

        idle(); dmem_req_mem = 1'b1;
        chk("to_run", C_DSTALL);
        for (int i = 1; i <= 5; i++) begin
            #3;
            lit("to_err_level", {9'd0, wait_err}, (i > TO) ? 10'd1 : 10'd0);
            lit("to_ctl", ctl, C_DSTALL);
            tick();
        end
        dhit = 1'b1;                 chk("to_hit", C_FLOW);
        idle(); tick(); tick(); #3;
        lit("err_sticky", {9'd0, wait_err}, 10'd1);
        RST = 1'b1; tick(); #3;
        lit("err_cleared", {9'd0, wait_err}, 10'd0);
        RST = 1'b0; tick();

        idle(); halt_mem_wb = 1'b1;  chk("halt_cycle", C_HALT);
        idle(); #3;
        lit("halted_flag", {9'd0, halted}, 10'd1);
        lit("halted_ctl", ctl, C_IDLE);
        tick(); tick(); #3;
        lit("halted_hold", {halted, ctl[8:0]}, 10'b1000000000);
        tick();
        RST = 1'b1; #3;
        lit("halt_reset", {9'd0, halted}, 10'd0);
        tick();
        RST = 1'b0; tick();

        for (int n = 0; n < 4000; n++) begin
            ihit            = ($urandom_range(0, 4) != 0);
            dhit            = ($urandom_range(0, 2) != 0);
            dmem_req_mem    = ($urandom_range(0, 2) == 0);
            regwrite_id_ex  = ($urandom_range(0, 1) == 1);
            memtoreg_id_ex  = 2'($urandom_range(0, 3));
            dest_id_ex      = 5'($urandom_range(0, 7));
            instr_if_id     = $urandom;
            instr_if_id[25:21] = 5'($urandom_range(0, 7));
            instr_if_id[20:16] = 5'($urandom_range(0, 7));
            pcsrc_taken_mem = ($urandom_range(0, 5) == 0);
            halt_mem_wb     = ($urandom_range(0, 60) == 0);
            RST             = ($urandom_range(0, 45) == 0);
            tick();
        end
        RST = 1'b0;
        idle();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It consumes hit/request status from the cache interface and hazard fields from the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It drives per-latch enable and flush controls, PC enable, and instruction-fetch arbitration. It complements the operand-forwarding unit by covering every hazard forwarding cannot resolve: load-use, memory wait, taken branch/jump, and halt.

Parameters:
REG_AW, 5, register-address width
DWAIT_TIMEOUT, 255, max consecutive dmem-wait cycles before wait_err; 0 disables the watchdog
CNT_W, 32, width of the optional performance counters

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dmem_req_mem  in  1  EX/MEM holds a load or store
regwrite_id_ex  in  1  ID/EX instruction writes a register
memtoreg_id_ex  in  2  ID/EX writeback source; 2 = load data
dest_id_ex  in  REG_AW  ID/EX destination register
instr_if_id  in  32  IF/ID instruction; rs = [25:21], rt = [20:16]
pcsrc_taken_mem  in  1  branch/jump resolved taken in MEM
halt_mem_wb  in  1  halt instruction in MEM/WB
pc_en  out  1  PC update enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  latch enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load bubble (all control zero)
imem_ren  out  1  instruction fetch request
halted  out  1  sticky halt indication
wait_err  out  1  sticky dmem-wait watchdog flag

Behaviour:
- Reset:
  - state = RUN; wait counter = 0.
  - halted = 0, wait_err = 0.
  - All enables = 0, all flushes = 0, pc_en = 0, imem_ren = 0.
- FSM states: RUN, DWAIT, HALTED. The state is registered; outputs are combinational from the state plus inputs.
- RUN, evaluated in priority order:
  1. halt_mem_wb:
     - Next state HALTED.
     - This cycle: every enable = 0, pc_en = 0.
  2. dmem_req_mem && !dhit:
     - Next state DWAIT.
     - This cycle: all enables = 0, pc_en = 0, mem_wb_flush = 1, imem_ren = 0. The data port has priority over instruction fetch.
  3. pcsrc_taken_mem:
     - pc_en = 1; all enables = 1.
     - if_id_flush = id_ex_flush = ex_mem_flush = 1 (1-cycle, 3-bubble squash).
  4. Load-use, when regwrite_id_ex && memtoreg_id_ex == 2 && dest_id_ex != 0 && (dest_id_ex == rs || dest_id_ex == rt):
     - pc_en = 0, if_id_en = 0, id_ex_flush = 1.
     - Other stages enabled.
     - This gives exactly one bubble, because the load advances to MEM next cycle.
  5. !ihit:
     - pc_en = 0, if_id_en = 0, id_ex_flush = 1; the rest advances.
  6. Otherwise:
     - All enables = 1, pc_en = 1, no flush.
  - imem_ren = 1 in RUN except in case 2.
- DWAIT:
  - All enables = 0, pc_en = 0, mem_wb_flush = 1, imem_ren = 0.
  - On dhit: the RUN priority evaluation is applied in the same cycle with the dmem condition treated as satisfied, then next state is RUN.
  - This means a branch held in MEM during the wait flushes in the dhit cycle.
- Wait counter:
  - Increments each DWAIT cycle, saturating at 2^8−1.
  - Cleared on leaving DWAIT.
  - If DWAIT_TIMEOUT != 0 and the counter reaches DWAIT_TIMEOUT, wait_err is set. wait_err is sticky until RST.
- HALTED:
  - All enables, flushes, pc_en and imem_ren = 0.
  - halted = 1 (registered, set on entry). The only exit is RST.
- Simultaneous events:
  - Branch + load-use: the branch wins and the dependent instruction is squashed.
  - Branch + !ihit: the branch wins, pc_en = 1 and the fetched slot is flushed.
  - dmem wait + halt: halt is not yet visible, since halt is in WB only.
- RST asserted mid-DWAIT: immediate return to the reset values; no pending request is retained.

Optional Feature:
Macro PIPE_PERF_EN.
- When defined:
  - Adds outputs stall_cycles and flush_events, each CNT_W bits wide.
  - stall_cycles increments on any cycle with pc_en = 0 outside HALTED.
  - flush_events increments once per taken-branch flush.
  - Both saturate at all-ones and are reset to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (cpu_types_pkg):
  - word_t and regbits_t.
  - Memtoreg encoding constant MEMTOREG_LOAD = 2.
  - Enum pctl_state_t {RUN, DWAIT, HALTED}.
- Sub-module hazard_detect: purely combinational load-use comparator, with one instance.

Test Plan:
- Load into r5 in ID/EX; IF/ID instruction is add with rs = 5 → one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1; next cycle all enables = 1.
- Same as above, but dest = 0 or rt/rs mismatch → no stall.
- dmem_req_mem = 1 with dhit low for 3 cycles → 3 cycles of all enables 0, mem_wb_flush = 1, imem_ren = 0; dhit cycle enables all stages; 4 cycles total.
- pcsrc_taken_mem = 1 coincident with a load-use condition → if_id/id_ex/ex_mem flush = 1, pc_en = 1, no stall.
- DWAIT_TIMEOUT = 4 with dhit held low 6 cycles → wait_err rises on the 4th DWAIT cycle and stays high after dhit; cleared only by RST.
- halt_mem_wb pulse → halted = 1 next cycle, all outputs 0 thereafter; RST mid-halt → state RUN, halted = 0.
